eu_result_icon_tx: RTL and testbench

//  Transmit end of the interconnect tx/rx channel pair (pkg_dtypes). Sits between an exec unit's ALU

---
 rtl/eu_result_icon_tx.sv | 120 ++++++++++++
 tb/tb_eu_result_icon_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/eu_result_icon_tx.sv
// Interconnect tx channel types plus eu_result_icon_tx: buffers ALU results
// in a FIFO and presents them one at a time on the interconnect tx channel.
// Each result is held there until the interconnect returns success.
// Ports:
//   clk, reset (sync, active-high), flush (sync discard of all buffered results)
//   i_alu_tx       : ALU result channel (opd_data/opd_addr/opd_valid)
//   o_alu_store_ok : accept back to the ALU (opd_store_success)
//   o_icon_tx      : addr/data/valid toward the interconnect
//   i_icon_rx      : success from the interconnect
//   o_count        : entries currently buffered
//   o_stall_cnt    : cycles the current head has waited, saturating
package pkg_dtypes;

    typedef struct packed {
        logic [3:0] euidx;
        logic [7:0] uid;
        logic [3:0] spec;
    } type_icon_addr;

    typedef struct packed {
        logic [15:0]   opd_data;
        type_icon_addr opd_addr;
        logic          opd_valid;
    } type_alu_channel_tx;

    typedef struct packed {
        type_icon_addr addr;
        logic [15:0]   data;
        logic          valid;
    } type_icon_tx_channel;

    typedef struct packed {
        logic success;
    } type_icon_rx_channel;

    typedef struct packed {
        type_icon_addr addr;
        logic [15:0]   data;
    } type_result_entry;

endpackage

module eu_result_icon_tx
    import pkg_dtypes::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned STALL_CNT_BITS = 8,
    localparam int unsigned PTR_W         = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  type_alu_channel_tx        i_alu_tx,
    output logic                      o_alu_store_ok,
    output type_icon_tx_channel       o_icon_tx,
    input  type_icon_rx_channel       i_icon_rx,
    output logic [CNT_W-1:0]          o_count,
    output logic [STALL_CNT_BITS-1:0] o_stall_cnt
);

    type_result_entry mem [FIFO_DEPTH];

    logic [PTR_W-1:0]          rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CNT_W-1:0]          count_nxt;
    logic [STALL_CNT_BITS-1:0] stall_nxt;
    logic                      push, pop;
    type_result_entry          new_entry, head_nxt;

    // Next-state for pointers, count, stall counter and the registered head.
    always_comb begin
        new_entry  = '{addr: i_alu_tx.opd_addr, data: i_alu_tx.opd_data};
        push       = i_alu_tx.opd_valid && o_alu_store_ok && !flush;
        pop        = o_icon_tx.valid && i_icon_rx.success && !flush;
        rd_ptr_nxt = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_ptr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        count_nxt  = o_count + CNT_W'(push) - CNT_W'(pop);
        stall_nxt  = '0;
        if (o_icon_tx.valid && !i_icon_rx.success) begin
            stall_nxt = (&o_stall_cnt) ? o_stall_cnt : o_stall_cnt + STALL_CNT_BITS'(1);
        end
        if (flush) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
            stall_nxt  = '0;
        end
        // Only a push into a slot that becomes the head must be forwarded from the input.
        head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? new_entry : mem[rd_ptr_nxt];
    end

    // Result storage; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            o_count        <= '0;
            o_stall_cnt    <= '0;
            o_alu_store_ok <= 1'b1;
            o_icon_tx      <= '0;
        end else begin
            rd_ptr          <= rd_ptr_nxt;
            wr_ptr          <= wr_ptr_nxt;
            o_count         <= count_nxt;
            o_stall_cnt     <= stall_nxt;
            o_alu_store_ok  <= (count_nxt < CNT_W'(FIFO_DEPTH));
            o_icon_tx.valid <= (count_nxt != '0);
            o_icon_tx.addr  <= (count_nxt != '0) ? head_nxt.addr : '0;
            o_icon_tx.data  <= (count_nxt != '0) ? head_nxt.data : '0;
        end
    end

endmodule

// File: tb/tb_eu_result_icon_tx.sv
// Self-checking bench for eu_result_icon_tx: a reference queue is filled when
// a result is accepted and popped when the interconnect handshake completes;
// the DUT outputs are compared against it every cycle on the falling edge.
module tb_eu_result_icon_tx;
    import pkg_dtypes::*;

    localparam int unsigned DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset, flush;
    type_alu_channel_tx  alu;
    logic                store_ok;
    type_icon_tx_channel tx;
    type_icon_rx_channel rx;
    logic [2:0]          count;
    logic [7:0]          stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        chk_en   = 1'b0;

    type_result_entry q[$];
    int unsigned      exp_stall = 0;

    always #5 clk = ~clk;

    eu_result_icon_tx #(.FIFO_DEPTH(DEPTH), .STALL_CNT_BITS(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .i_alu_tx       (alu),
        .o_alu_store_ok (store_ok),
        .o_icon_tx      (tx),
        .i_icon_rx      (rx),
        .o_count        (count),
        .o_stall_cnt    (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    function automatic type_icon_addr mk_addr(input int unsigned e, input int unsigned u,
                                              input int unsigned s);
        return '{euidx: 4'(e), uid: 8'(u), spec: 4'(s)};
    endfunction

    // Drive one cycle of stimulus, then advance just past the next rising edge.
    task automatic drive(input logic v, input logic [15:0] d, input type_icon_addr a,
                         input logic s, input logic f);
        alu.opd_valid = v;
        alu.opd_data  = d;
        alu.opd_addr  = a;
        rx.success    = s;
        flush         = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic s, input int unsigned n);
        for (int i = 0; i < int'(n); i++) drive(1'b0, 16'h0, mk_addr(0, 0, 0), s, 1'b0);
    endtask

    // Hold success until the DUT reports empty, bounded.
    task automatic drain(input string tag);
        int unsigned waited = 0;
        while (count != 3'd0 && waited < 40) begin
            drive(1'b0, 16'h0, mk_addr(0, 0, 0), 1'b1, 1'b0);
            waited++;
        end
        check({tag, "_drain"}, 64'(count), 64'd0);
    endtask

    // Per-cycle compare against the reference, then advance the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count", 64'(count), 64'(q.size()));
            check("store_ok", 64'(store_ok), 64'(q.size() < DEPTH));
            check("valid", 64'(tx.valid), 64'(q.size() != 0));
            check("stall", 64'(stall_cnt), 64'(exp_stall));
            if (q.size() != 0) begin
                check("head_addr", 64'(tx.addr), 64'(q[0].addr));
                check("head_data", 64'(tx.data), 64'(q[0].data));
            end else begin
                check("idle_addr", 64'(tx.addr), 64'd0);
                check("idle_data", 64'(tx.data), 64'd0);
            end
            if (reset || flush) begin
                q.delete();
                exp_stall = 0;
            end else begin
                automatic logic m_valid = (q.size() != 0);
                automatic logic do_pop  = m_valid && rx.success;
                automatic logic do_push = alu.opd_valid && (q.size() < DEPTH);
                if (m_valid && !rx.success) exp_stall = (exp_stall == 255) ? 255 : exp_stall + 1;
                else exp_stall = 0;
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back('{addr: alu.opd_addr, data: alu.opd_data});
            end
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        alu   = '0;
        rx    = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1'b0, 2);
        reset = 1'b0;

        // Idle after reset.
        idle(1'b1, 10);

        // Single push with success held: visible one cycle later, then consumed.
        check("t2_pre_valid", 64'(tx.valid), 64'd0);
        drive(1'b1, 16'h00A5, mk_addr(1, 2, 3), 1'b1, 1'b0);
        check("t2_valid", 64'(tx.valid), 64'd1);
        check("t2_data", 64'(tx.data), 64'h00A5);
        check("t2_addr", 64'(tx.addr), 64'(mk_addr(1, 2, 3)));
        check("t2_count1", 64'(count), 64'd1);
        idle(1'b1, 1);
        check("t2_count0", 64'(count), 64'd0);
        idle(1'b1, 2);

        // Held head under back-pressure; stall counter climbs then clears on pop.
        drive(1'b1, 16'hBEEF, mk_addr(2, 7, 1), 1'b0, 1'b0);
        idle(1'b0, 5);
        check("t3_stall5", 64'(stall_cnt), 64'd5);
        idle(1'b1, 1);
        check("t3_stall_clr", 64'(stall_cnt), 64'd0);
        check("t3_empty", 64'(count), 64'd0);
        idle(1'b1, 2);

        // Fill to depth, fifth offer refused, drain across pointer wrap.
        for (int i = 1; i <= 5; i++) drive(1'b1, 16'(i), mk_addr(i, i, i), 1'b0, 1'b0);
        check("t4_full", 64'(count), 64'd4);
        check("t4_store_ok", 64'(store_ok), 64'd0);
        idle(1'b1, 4);
        check("t4_drained", 64'(count), 64'd0);

        // Concurrent push and pop at count 2.
        drive(1'b1, 16'h10, mk_addr(3, 16, 0), 1'b0, 1'b0);
        drive(1'b1, 16'h11, mk_addr(3, 17, 0), 1'b0, 1'b0);
        for (int i = 2; i < 8; i++) begin
            drive(1'b1, 16'(16 + i), mk_addr(3, 16 + i, 0), 1'b1, 1'b0);
            check("t5_count2", 64'(count), 64'd2);
        end
        drain("t5");

        // Flush with three buffered plus a concurrent push.
        for (int i = 0; i < 3; i++) drive(1'b1, 16'(32 + i), mk_addr(4, i, 0), 1'b0, 1'b0);
        drive(1'b1, 16'h0077, mk_addr(4, 9, 9), 1'b1, 1'b1);
        check("t6_flush_cnt", 64'(count), 64'd0);
        check("t6_flush_valid", 64'(tx.valid), 64'd0);
        drive(1'b1, 16'h0055, mk_addr(5, 5, 5), 1'b0, 1'b0);
        check("t6_post_data", 64'(tx.data), 64'h0055);
        drain("t6");

        // Stall counter saturation.
        drive(1'b1, 16'h0F0F, mk_addr(6, 6, 6), 1'b0, 1'b0);
        idle(1'b0, 260);
        check("sat_stall", 64'(stall_cnt), 64'd255);
        drain("sat");

        // Reset while transferring drops the buffered results.
        drive(1'b1, 16'h0A0A, mk_addr(7, 1, 1), 1'b0, 1'b0);
        drive(1'b1, 16'h0B0B, mk_addr(7, 2, 2), 1'b0, 1'b0);
        reset = 1'b1;
        idle(1'b0, 2);
        reset = 1'b0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_store_ok", 64'(store_ok), 64'd1);

        // Random traffic with occasional flush.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), mk_addr($urandom, $urandom, $urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end
        drain("rand");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
